// File: rtl/snax_csr_bridge.sv
// Bridge between the Snitch accelerator request/response port and a SNAX CSR port.
// An in-order ID FIFO pairs each response with its request; out-of-range CSRs are answered locally.
package snax_csr_bridge_pkg;
    typedef struct packed {
        logic [31:0] data_op;
        logic [63:0] data_arga;
        logic [63:0] data_argb;
        logic [4:0]  id;
    } acc_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  id;
        logic        error;
    } acc_rsp_t;
endpackage

module snax_csr_bridge #(
    parameter type         acc_req_t      = snax_csr_bridge_pkg::acc_req_t,
    parameter type         acc_rsp_t      = snax_csr_bridge_pkg::acc_rsp_t,
    parameter logic [31:0] CsrAddrOffset  = 32'h3c0,
    parameter int unsigned NumCsr         = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 5
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  acc_req_t                              snax_req_i,
    input  logic                                  snax_qvalid_i,
    output logic                                  snax_qready_o,
    output acc_rsp_t                              snax_resp_o,
    output logic                                  snax_pvalid_o,
    input  logic                                  snax_pready_i,
    output logic [31:0]                           snax_csr_req_bits_data_o,
    output logic [31:0]                           snax_csr_req_bits_addr_o,
    output logic                                  snax_csr_req_bits_write_o,
    output logic                                  snax_csr_req_valid_o,
    input  logic                                  snax_csr_req_ready_i,
    input  logic [31:0]                           snax_csr_rsp_bits_data_i,
    input  logic                                  snax_csr_rsp_valid_i,
    output logic                                  snax_csr_rsp_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    // Handshake: a transfer happens on a channel in every cycle where valid and ready are both high.
    logic [IdWidth-1:0]  id_mem  [MaxOutstanding];
    logic                err_mem [MaxOutstanding];
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr;
    logic [CntWidth-1:0] count;

    logic        full;
    logic        empty;
    logic        is_read;
    logic        in_range;
    logic        push;
    logic        pop;
    logic [31:0] csr_addr;

    assign full  = (count == CntWidth'(MaxOutstanding));
    assign empty = (count == '0);

    // SYSTEM opcode with funct3[1] set covers CSRRS/CSRRC/CSRRSI/CSRRCI.
    assign is_read  = (snax_req_i.data_op[6:0] == 7'b1110011) && snax_req_i.data_op[13];
    assign csr_addr = snax_req_i.data_argb[31:0] - CsrAddrOffset;
    assign in_range = (csr_addr < 32'(NumCsr));

    assign snax_csr_req_bits_data_o  = snax_req_i.data_arga[31:0];
    assign snax_csr_req_bits_addr_o  = csr_addr;
    assign snax_csr_req_bits_write_o = snax_qvalid_i && !is_read;
    assign snax_csr_req_valid_o      = snax_qvalid_i && in_range && !full;
    assign snax_qready_o             = !full && (in_range ? snax_csr_req_ready_i : 1'b1);

    assign push = snax_qvalid_i && snax_qready_o;
    assign pop  = snax_pvalid_o && snax_pready_i;

    always_comb begin
        snax_resp_o          = '0;
        snax_resp_o.id       = id_mem[rd_ptr];
        snax_pvalid_o        = 1'b0;
        snax_csr_rsp_ready_o = 1'b0;
        if (!empty) begin
            if (err_mem[rd_ptr]) begin
                snax_pvalid_o     = 1'b1;
                snax_resp_o.error = 1'b1;
            end else begin
                snax_pvalid_o          = snax_csr_rsp_valid_i;
                snax_csr_rsp_ready_o   = snax_pready_i;
                snax_resp_o.data[31:0] = snax_csr_rsp_bits_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr + PtrWidth'(1);
            end
            if (push && !pop) begin
                count <= count + CntWidth'(1);
            end else if (pop && !push) begin
                count <= count - CntWidth'(1);
            end
        end
    end

    // Entry payload needs no reset: it is only observed while count says it is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr]  <= snax_req_i.id;
            err_mem[wr_ptr] <= !in_range;
        end
    end

    assign outstanding_o = count;

endmodule

// File: tb/tb_snax_csr_bridge.sv
// Directed bench for snax_csr_bridge: decode, range check, ordering, full FIFO and async reset.
module tb_snax_csr_bridge;
    import snax_csr_bridge_pkg::*;

    localparam logic [31:0] OP_CSRRW = 32'h0000_1073;
    localparam logic [31:0] OP_CSRRS = 32'h0000_2073;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    acc_req_t    req;
    logic        qvalid, qready;
    acc_rsp_t    resp;
    logic        pvalid, pready;
    logic [31:0] csr_req_data, csr_req_addr;
    logic        csr_req_write, csr_req_valid, csr_req_ready;
    logic [31:0] csr_rsp_data;
    logic        csr_rsp_valid, csr_rsp_ready;
    logic [2:0]  outstanding;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snax_csr_bridge dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_ni),
        .snax_req_i                (req),
        .snax_qvalid_i             (qvalid),
        .snax_qready_o             (qready),
        .snax_resp_o               (resp),
        .snax_pvalid_o             (pvalid),
        .snax_pready_i             (pready),
        .snax_csr_req_bits_data_o  (csr_req_data),
        .snax_csr_req_bits_addr_o  (csr_req_addr),
        .snax_csr_req_bits_write_o (csr_req_write),
        .snax_csr_req_valid_o      (csr_req_valid),
        .snax_csr_req_ready_i      (csr_req_ready),
        .snax_csr_rsp_bits_data_i  (csr_rsp_data),
        .snax_csr_rsp_valid_i      (csr_rsp_valid),
        .snax_csr_rsp_ready_o      (csr_rsp_ready),
        .outstanding_o             (outstanding)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] op, input logic [31:0] csr,
                             input logic [31:0] arga, input logic [4:0] id);
        req.data_op   = op;
        req.data_argb = {32'h0, csr};
        req.data_arga = {32'h0, arga};
        req.id        = id;
        qvalid        = 1'b1;
    endtask

    initial begin
        req = '0; qvalid = 1'b0; pready = 1'b0; csr_req_ready = 1'b1;
        csr_rsp_data = '0; csr_rsp_valid = 1'b0;

        // Reset state
        #1;
        check("rst_outstanding", outstanding, 0);
        check("rst_pvalid", pvalid, 0);
        check("rst_csr_req_valid", csr_req_valid, 0);
        check("rst_csr_rsp_ready", csr_rsp_ready, 0);
        @(negedge clk); rst_ni = 1'b1;

        // Write then read to CSR 0x3c5
        @(negedge clk);
        drive_req(OP_CSRRW, 32'h3c5, 32'hDEAD_BEEF, 5'd3);
        #1;
        check("wr_addr", csr_req_addr, 5);
        check("wr_write", csr_req_write, 1);
        check("wr_data", csr_req_data, 32'hDEAD_BEEF);
        check("wr_valid", csr_req_valid, 1);
        check("wr_qready", qready, 1);
        @(negedge clk);
        drive_req(OP_CSRRS, 32'h3c5, 32'h0, 5'd4);
        #1;
        check("rd_write", csr_req_write, 0);
        check("rd_valid", csr_req_valid, 1);
        check("rd_outstanding", outstanding, 1);
        check("rd_pvalid_wait", pvalid, 0);
        @(negedge clk);
        qvalid = 1'b0; csr_rsp_valid = 1'b1; csr_rsp_data = 32'h0; pready = 1'b1;
        #1;
        check("rsp1_pvalid", pvalid, 1);
        check("rsp1_id", resp.id, 3);
        check("rsp1_error", resp.error, 0);
        check("rsp1_csr_rsp_ready", csr_rsp_ready, 1);
        check("rsp1_outstanding", outstanding, 2);
        check("idle_write", csr_req_write, 0);
        @(negedge clk);
        csr_rsp_data = 32'h1234;
        #1;
        check("rsp2_id", resp.id, 4);
        check("rsp2_data", resp.data, 64'h1234);
        check("rsp2_error", resp.error, 0);
        @(negedge clk);
        #1;
        // Stray CSR response with an empty FIFO must stall
        check("stray_pvalid", pvalid, 0);
        check("stray_csr_rsp_ready", csr_rsp_ready, 0);
        check("empty_outstanding", outstanding, 0);
        csr_rsp_valid = 1'b0;

        // Out of range: 0x3c0 + 32
        @(negedge clk);
        csr_req_ready = 1'b0;
        drive_req(OP_CSRRW, 32'h3e0, 32'h1, 5'd7);
        #1;
        check("oor_csr_req_valid", csr_req_valid, 0);
        check("oor_qready", qready, 1);
        check("oor_pvalid_same_cycle", pvalid, 0);
        @(negedge clk);
        qvalid = 1'b0; csr_req_ready = 1'b1;
        #1;
        check("oor_pvalid", pvalid, 1);
        check("oor_id", resp.id, 7);
        check("oor_data", resp.data, 0);
        check("oor_error", resp.error, 1);
        check("oor_csr_rsp_ready", csr_rsp_ready, 0);

        // Below offset wraps to out of range
        @(negedge clk);
        drive_req(OP_CSRRS, 32'h3bf, 32'h0, 5'd9);
        #1;
        check("below_csr_req_valid", csr_req_valid, 0);
        check("below_write", csr_req_write, 0);
        @(negedge clk);
        qvalid = 1'b0;
        #1;
        check("below_id", resp.id, 9);
        check("below_error", resp.error, 1);
        @(negedge clk);
        pready = 1'b0;
        #1;
        check("below_drained", outstanding, 0);

        // Fill the FIFO with four reads
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(OP_CSRRS, 32'h3c0 + i, 32'h0, 5'(10 + i));
        end
        @(negedge clk);
        drive_req(OP_CSRRS, 32'h3c4, 32'h0, 5'd14);
        #1;
        check("full_outstanding", outstanding, 4);
        check("full_qready", qready, 0);
        check("full_csr_req_valid", csr_req_valid, 0);
        csr_rsp_valid = 1'b1; csr_rsp_data = 32'hA; pready = 1'b1;
        #1;
        check("full_pop_id", resp.id, 10);
        check("full_qready_during_pop", qready, 0);
        @(negedge clk);
        csr_rsp_valid = 1'b0; pready = 1'b0;
        #1;
        check("after_pop_outstanding", outstanding, 3);
        check("after_pop_qready", qready, 1);
        @(negedge clk);
        qvalid = 1'b0; csr_rsp_valid = 1'b1; pready = 1'b1;
        #1;
        check("refill_outstanding", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_id", resp.id, 64'(11 + i));
            @(negedge clk);
            #1;
        end
        check("drain_outstanding", outstanding, 0);
        csr_rsp_valid = 1'b0;

        // Local error queued behind a pending read
        @(negedge clk);
        drive_req(OP_CSRRS, 32'h3c1, 32'h0, 5'd1);
        @(negedge clk);
        drive_req(OP_CSRRW, 32'h400, 32'h0, 5'd2);
        @(negedge clk);
        qvalid = 1'b0;
        #1;
        check("mixed_outstanding", outstanding, 2);
        check("mixed_hold_pvalid", pvalid, 0);
        @(negedge clk);
        #1;
        check("mixed_hold_pvalid2", pvalid, 0);
        csr_rsp_valid = 1'b1; csr_rsp_data = 32'h55;
        #1;
        check("mixed_first_id", resp.id, 1);
        check("mixed_first_data", resp.data, 64'h55);
        @(negedge clk);
        csr_rsp_valid = 1'b0;
        #1;
        check("mixed_second_pvalid", pvalid, 1);
        check("mixed_second_id", resp.id, 2);
        check("mixed_second_error", resp.error, 1);
        @(negedge clk);
        pready = 1'b0;

        // Async reset with three entries outstanding
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_req(OP_CSRRS, 32'h3c2, 32'h0, 5'(20 + i));
        end
        @(negedge clk);
        qvalid = 1'b0;
        #1;
        check("pre_reset_outstanding", outstanding, 3);
        csr_rsp_valid = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check("async_rst_outstanding", outstanding, 0);
        check("async_rst_pvalid", pvalid, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_outstanding", outstanding, 0);
        check("post_rst_pvalid", pvalid, 0);
        csr_rsp_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snax_csr_bridge.md
# snax_csr_bridge

Parametrised, buffered bridge between the Snitch accelerator request/response port and a SNAX accelerator's simplified CSR port. It decodes CSR read and write operations and range-checks the CSR address. An in-order ID FIFO tracks outstanding transactions, so each response carries the ID of its own request. Out-of-range accesses are answered locally with an error response. It sits between the Snitch core's accelerator interface and each SNAX accelerator's CSR manager.

## Interface
- `acc_req_t`, logic: Snitch accelerator request struct (`data_op`, `data_arga`, `data_argb`, `id`).
- `acc_rsp_t`, logic: Snitch accelerator response struct (`data`, `id`, `error`).
- `CsrAddrOffset`, 32'h3c0: CSR number mapped to accelerator CSR address 0.
- `NumCsr`, 32: number of accelerator CSRs; legal addresses are 0..NumCsr-1.
- `MaxOutstanding`, 4: ID FIFO depth, ≥1, need not be a power of 2.
- `IdWidth`, 5: width of `acc_req_t.id`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `snax_req_i`  in  acc_req_t  request payload.
- `snax_qvalid_i`  in  1  request valid.
- `snax_qready_o`  out  1  request ready.
- `snax_resp_o`  out  acc_rsp_t  response payload.
- `snax_pvalid_o`  out  1  response valid.
- `snax_pready_i`  in  1  response ready.
- `snax_csr_req_bits_data_o`  out  32  write data, equal to `data_arga[31:0]`.
- `snax_csr_req_bits_addr_o`  out  32  `data_argb - CsrAddrOffset`, modulo 2^32.
- `snax_csr_req_bits_write_o`  out  1  1 = write.
- `snax_csr_req_valid_o`  out  1  CSR request valid.
- `snax_csr_req_ready_i`  in  1  CSR request ready.
- `snax_csr_rsp_bits_data_i`  in  32  CSR read data.
- `snax_csr_rsp_valid_i`  in  1  CSR response valid.
- `snax_csr_rsp_ready_o`  out  1  CSR response ready.
- `outstanding_o`  out  $clog2(MaxOutstanding+1)  current FIFO occupancy.

## Operation
- Decode: CSRRS, CSRRSI, CSRRC and CSRRCI are reads (`write_o`=0). Every other op is a write. `write_o` is 0 whenever `qvalid`=0.
- Range: `in_range` = (`data_argb - CsrAddrOffset`) < `NumCsr`, compared unsigned on 32 bits. An address below the offset wraps and is therefore out of range.
- Accept conditions:
  - `csr_req_valid_o` = `qvalid` & `in_range` & !full.
  - `qready_o` = !full & (`in_range` ? `csr_req_ready_i` : 1).
  - Accept = `qvalid` & `qready`. On accept, push {`id`, `local_err` = !`in_range`}.
- Every in-range accept, read or write, expects exactly one CSR response. Out-of-range accepts issue nothing on the CSR side.
- Response, head entry with `local_err`=0:
  - `pvalid` = `csr_rsp_valid_i`.
  - `csr_rsp_ready_o` = `pready`.
  - `resp.data` = `csr_rsp_bits_data_i`, `resp.error` = 0.
- Response, head entry with `local_err`=1:
  - `pvalid` = 1.
  - `csr_rsp_ready_o` = 0.
  - `resp.data` = 0, `resp.error` = 1.
- Empty FIFO: `pvalid`=0, `csr_rsp_ready_o`=0. A stray CSR response stalls and is not consumed.
- `resp.id` is always the head ID. Pop on `pvalid` & `pready`.
- FIFO:
  - Read and write pointers wrap from MaxOutstanding-1 to 0.
  - Count increments on push only and decrements on pop only. Simultaneous push and pop leaves the count unchanged.
  - When full, push is blocked even if a pop occurs in the same cycle. `qready` never depends on `pready`.

## Timing
- Request path is combinational: CSR request in the same cycle as `qvalid`. The ID capture is registered.
- Response path is combinational from head and `csr_rsp_*`. A local error response is valid at the earliest 1 cycle after its accept.
- Reset values: pointers, count and `outstanding_o` are 0. `pvalid`, `csr_rsp_ready_o` and `csr_req_valid_o` are 0 while `qvalid`=0. Reset mid-transaction discards all entries.
- Ordering is strictly in order. A local error queued behind a pending CSR read waits for that read.

## Test plan
- Write then read: CSRRW to CSR 0x3c5 with arga=0xDEAD_BEEF, id=3, then CSRRS to 0x3c5, id=4. Required: `addr_o`=5, `write_o`=1 then 0, responses carry id 3 then id 4, `error`=0.
- Out of range: CSRRW to 0x3c0+NumCsr, id=7. Required: no `csr_req_valid_o`, one cycle later a response with id=7, data=0, error=1.
- Below offset: CSRRS to 0x3bf. Required: treated as out of range, error response.
- Full FIFO: 4 reads accepted with `csr_rsp_valid`=0. Required: `outstanding_o`=4, `qready`=0. Pop one response while a fifth request is valid: the fifth is accepted only on the next cycle.
- Mixed order: read id=1 is pending while out-of-range id=2 is queued. Required: id=2 is not presented until id=1 has returned.
- Async reset asserted with 3 entries outstanding. Required: `outstanding_o`=0 immediately and `pvalid`=0.
